// File: rtl/stopwatch_pkg.sv
// Shared encodings, default timing constants and counter-width helper
// for the stopwatch control sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } sw_state_e;

  localparam int unsigned CLK_HZ_DEF          = 32'd100_000_000;
  localparam int unsigned TICK_HZ_DEF         = 32'd100;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd1_000_000;

  // Bits needed to count 0..n_states-1 (never less than one bit)
  function automatic int unsigned cnt_width(input int unsigned n_states);
    return (n_states < 32'd2) ? 32'd1 : int'($clog2(n_states));
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_button_debounce.sv
// Raw push-button conditioning: 2-FF synchroniser, stability debounce and
// a registered single-cycle pulse on each accepted press.
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_stopwatch,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned    CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 32'd1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state for synchroniser, debounce counter and press pulse
  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    level_dly_d = level_q;
    level_d     = level_q;
    cnt_d       = cnt_q;
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_MAX) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
    // Only a debounced 0->1 change is a press; releases are silent
    press_d = level_q & ~level_dly_q;
  end

  // Conditioning state registers
  always_ff @(posedge clk or posedge reset_stopwatch) begin
    if (reset_stopwatch) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, 100 Hz tick prescaler
// and the IDLE/RUN/PAUSE/LAP machine driving datapath strobes.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ          = CLK_HZ_DEF,
  parameter int unsigned TICK_HZ         = TICK_HZ_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset_stopwatch,
  input  logic       btn_startstop,
  input  logic       btn_lap,
  output logic       count_en,
  output logic       count_clr,
  output logic       lap_latch,
  output logic       display_hold,
  output logic       run_led,
  output logic [1:0] state
);

  localparam int unsigned   TICK_DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned   PW        = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 32'd1);

  logic          ss_press, lp_press;
  sw_state_e     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          count_en_q, count_en_d;
  logic          count_clr_q, count_clr_d;
  logic          lap_latch_q, lap_latch_d;
  logic          display_hold_q, display_hold_d;
  logic          run_led_q, run_led_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_startstop (
    .clk             (clk),
    .reset_stopwatch (reset_stopwatch),
    .btn_raw         (btn_startstop),
    .press           (ss_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk             (clk),
    .reset_stopwatch (reset_stopwatch),
    .btn_raw         (btn_lap),
    .press           (lp_press)
  );

  // Prescaler advance, state transitions and strobe generation
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    count_en_d  = 1'b0;
    count_clr_d = 1'b0;
    lap_latch_d = 1'b0;

    // Prescaler follows the current state, so a wrap on a RUN->PAUSE edge still counts
    case (state_q)
      ST_RUN, ST_LAP: begin
        if (presc_q == PRESC_MAX) begin
          presc_d    = '0;
          count_en_d = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_PAUSE: presc_d = presc_q;
      default:  presc_d = '0;
    endcase

    // Start/stop always takes priority over lap/clear
    case (state_q)
      ST_IDLE: begin
        if (ss_press) state_d = ST_RUN;
        else          state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (ss_press) begin
          state_d = ST_PAUSE;
        end else if (lp_press) begin
          state_d     = ST_LAP;
          lap_latch_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LAP: begin
        if (ss_press)      state_d = ST_PAUSE;
        else if (lp_press) state_d = ST_RUN;
        else               state_d = ST_LAP;
      end
      ST_PAUSE: begin
        if (ss_press) begin
          state_d = ST_RUN;
        end else if (lp_press) begin
          state_d     = ST_IDLE;
          count_clr_d = 1'b1;
          presc_d     = '0;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    display_hold_d = (state_d == ST_LAP);
    run_led_d      = (state_d == ST_RUN) || (state_d == ST_LAP);
  end

  // Control state and registered outputs
  always_ff @(posedge clk or posedge reset_stopwatch) begin
    if (reset_stopwatch) begin
      state_q        <= ST_IDLE;
      presc_q        <= '0;
      count_en_q     <= 1'b0;
      count_clr_q    <= 1'b0;
      lap_latch_q    <= 1'b0;
      display_hold_q <= 1'b0;
      run_led_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      count_en_q     <= count_en_d;
      count_clr_q    <= count_clr_d;
      lap_latch_q    <= lap_latch_d;
      display_hold_q <= display_hold_d;
      run_led_q      <= run_led_d;
    end
  end

  assign count_en     = count_en_q;
  assign count_clr    = count_clr_q;
  assign lap_latch    = lap_latch_q;
  assign display_hold = display_hold_q;
  assign run_led      = run_led_q;
  assign state        = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random
// button activity, checked every cycle against a press-event reference model.
module tb_stopwatch_ctrl;

  localparam int CLK_HZ   = 1000;
  localparam int TICK_HZ  = 100;
  localparam int DB       = 4;
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSE  = 2;
  localparam int M_LAP    = 3;

  logic       clk;
  logic       reset_stopwatch;
  logic       btn_startstop;
  logic       btn_lap;
  logic       count_en;
  logic       count_clr;
  logic       lap_latch;
  logic       display_hold;
  logic       run_led;
  logic [1:0] state;

  int errors   = 0;
  int checks   = 0;
  int edge_n   = 0;
  int ss_act   = -100;
  int lp_act   = -100;
  int last_act = 0;
  int m_mode   = M_IDLE;
  int m_phase  = 0;
  bit model_on = 1'b0;
  bit exp_en, exp_clr, exp_lap;

  stopwatch_ctrl #(
    .CLK_HZ          (CLK_HZ),
    .TICK_HZ         (TICK_HZ),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk             (clk),
    .reset_stopwatch (reset_stopwatch),
    .btn_startstop   (btn_startstop),
    .btn_lap         (btn_lap),
    .count_en        (count_en),
    .count_clr       (count_clr),
    .lap_latch       (lap_latch),
    .display_hold    (display_hold),
    .run_led         (run_led),
    .state           (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Reference: presses act DB+3 edges after their first sampled raw edge
  task automatic model_step();
    bit ss_now, lp_now;
    ss_now  = (edge_n == ss_act);
    lp_now  = (edge_n == lp_act);
    exp_en  = 1'b0;
    exp_clr = 1'b0;
    exp_lap = 1'b0;
    if (m_mode == M_RUN || m_mode == M_LAP) begin
      m_phase = m_phase + 1;
      if (m_phase == TICK_DIV) begin
        m_phase = 0;
        exp_en  = 1'b1;
      end
    end else if (m_mode == M_IDLE) begin
      m_phase = 0;
    end
    if (ss_now) begin
      m_mode = (m_mode == M_RUN || m_mode == M_LAP) ? M_PAUSE : M_RUN;
    end else if (lp_now) begin
      if (m_mode == M_RUN) begin
        m_mode  = M_LAP;
        exp_lap = 1'b1;
      end else if (m_mode == M_LAP) begin
        m_mode = M_RUN;
      end else if (m_mode == M_PAUSE) begin
        m_mode  = M_IDLE;
        m_phase = 0;
        exp_clr = 1'b1;
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("state", 32'(state), 32'(m_mode));
    check_eq("count_en", 32'(count_en), 32'(exp_en));
    check_eq("count_clr", 32'(count_clr), 32'(exp_clr));
    check_eq("lap_latch", 32'(lap_latch), 32'(exp_lap));
    check_eq("display_hold", 32'(display_hold), 32'(m_mode == M_LAP));
    check_eq("run_led", 32'(run_led), 32'(m_mode == M_RUN || m_mode == M_LAP));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_state"}, 32'(state), 32'd0);
    check_eq({tag, "_count_en"}, 32'(count_en), 32'd0);
    check_eq({tag, "_count_clr"}, 32'(count_clr), 32'd0);
    check_eq({tag, "_lap_latch"}, 32'(lap_latch), 32'd0);
    check_eq({tag, "_display_hold"}, 32'(display_hold), 32'd0);
    check_eq({tag, "_run_led"}, 32'(run_led), 32'd0);
  endtask

  // Per-cycle lockstep check, sampled 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      edge_n = edge_n + 1;
      if (!reset_stopwatch && model_on) begin
        model_step();
        #1;
        if (!reset_stopwatch) compare_outputs();
      end
    end
  end

  // Called at a falling edge; the raw level is first sampled at edge_n+1
  task automatic press(input bit s, input bit l, input int hold);
    last_act = edge_n + DB + 4;
    if (s) begin
      ss_act        = last_act;
      btn_startstop = 1'b1;
    end
    if (l) begin
      lp_act  = last_act;
      btn_lap = 1'b1;
    end
    repeat (hold) @(negedge clk);
    btn_startstop = 1'b0;
    btn_lap       = 1'b0;
  endtask

  task automatic glitch(input bit s, input int len);
    if (s) btn_startstop = 1'b1;
    else   btn_lap       = 1'b1;
    repeat (len) @(negedge clk);
    btn_startstop = 1'b0;
    btn_lap       = 1'b0;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (edge_n < t) @(negedge clk);
  endtask

  task automatic press_and_settle(input bit s, input bit l);
    press(s, l, DB + 1);
    wait_until(last_act);
    repeat (DB + 2) @(negedge clk);
  endtask

  initial begin
    int cnt, cnt2, n, exp_wait, guard;
    reset_stopwatch = 1'b1;
    btn_startstop   = 1'b0;
    btn_lap         = 1'b0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    reset_stopwatch = 1'b0;
    model_on        = 1'b1;

    // Sub-threshold glitch must not register as a press
    glitch(1'b1, DB - 1);
    repeat (10) @(negedge clk);
    check_eq("glitch_state", 32'(state), 32'd0);

    // Run: ten ticks in the hundred cycles after entering RUN
    press(1'b1, 1'b0, DB + 2);
    wait_until(last_act);
    check_eq("run_state", 32'(state), 32'd1);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      cnt += int'(count_en);
    end
    check_eq("run_tick_count", 32'(cnt), 32'd10);
    check_eq("run_led_on", 32'(run_led), 32'd1);

    // Pause with the prescaler at 6, then resume
    guard = 0;
    while (((m_phase + DB + 3) % TICK_DIV) != 6 && guard < 2 * TICK_DIV) begin
      @(negedge clk);
      guard++;
    end
    check_eq("pause_align", 32'(guard < 2 * TICK_DIV), 32'd1);
    press(1'b1, 1'b0, DB + 1);
    wait_until(last_act);
    check_eq("pause_state", 32'(state), 32'd2);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      cnt += int'(count_en);
    end
    check_eq("pause_no_tick", 32'(cnt), 32'd0);
    press(1'b1, 1'b0, DB + 1);
    wait_until(last_act);
    exp_wait = TICK_DIV - m_phase;
    n = 0;
    while (!count_en && n < 3 * TICK_DIV) begin
      @(negedge clk);
      n++;
    end
    check_eq("resume_first_tick", 32'(n), 32'(exp_wait));

    // Lap: latch once, keep counting, then return to live display
    press(1'b0, 1'b1, DB + 1);
    wait_until(last_act);
    check_eq("lap_latch_pulse", 32'(lap_latch), 32'd1);
    check_eq("lap_display_hold", 32'(display_hold), 32'd1);
    cnt  = 0;
    cnt2 = 0;
    repeat (30) begin
      @(negedge clk);
      cnt  += int'(count_en);
      cnt2 += int'(lap_latch);
    end
    check_eq("lap_ticks", 32'(cnt), 32'd3);
    check_eq("lap_single_latch", 32'(cnt2), 32'd0);
    press(1'b0, 1'b1, DB + 1);
    wait_until(last_act);
    check_eq("unlap_state", 32'(state), 32'd1);
    check_eq("unlap_display", 32'(display_hold), 32'd0);
    repeat (DB + 2) @(negedge clk);

    // Clear from PAUSE, then simultaneous presses from RUN
    press_and_settle(1'b1, 1'b0);
    press(1'b0, 1'b1, DB + 1);
    wait_until(last_act);
    check_eq("clear_pulse", 32'(count_clr), 32'd1);
    check_eq("clear_state", 32'(state), 32'd0);
    repeat (DB + 2) @(negedge clk);
    press_and_settle(1'b1, 1'b0);
    press(1'b1, 1'b1, DB + 1);
    wait_until(last_act);
    check_eq("prio_state", 32'(state), 32'd2);
    check_eq("prio_no_latch", 32'(lap_latch), 32'd0);
    repeat (DB + 2) @(negedge clk);

    // Asynchronous reset in LAP, then full-latency press afterwards
    press_and_settle(1'b1, 1'b0);
    press_and_settle(1'b0, 1'b1);
    repeat (7) @(negedge clk);
    #2;
    reset_stopwatch = 1'b1;
    #1;
    check_all_zero("async_reset");
    m_mode  = M_IDLE;
    m_phase = 0;
    ss_act  = -100;
    lp_act  = -100;
    @(negedge clk);
    reset_stopwatch = 1'b0;
    press(1'b1, 1'b0, DB + 1);
    wait_until(last_act - 1);
    check_eq("post_reset_not_yet", 32'(state), 32'd0);
    wait_until(last_act);
    check_eq("post_reset_run", 32'(state), 32'd1);
    repeat (DB + 2) @(negedge clk);

    // Random button activity against the model
    repeat (40) begin
      case ($urandom_range(0, 5))
        0, 1:    press(1'b1, 1'b0, DB + int'($urandom_range(0, 5)));
        2:       press(1'b0, 1'b1, DB + int'($urandom_range(0, 5)));
        3:       press(1'b1, 1'b1, DB + int'($urandom_range(0, 5)));
        4:       glitch(1'($urandom_range(0, 1)), int'($urandom_range(1, DB - 1)));
        default: repeat ($urandom_range(1, 25)) @(negedge clk);
      endcase
      repeat (DB + 4 + int'($urandom_range(0, 15))) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
